// File: rtl/pc_stack_unit.sv
// Program counter with configurable step and reset vector, a stall input and
// a LIFO call/return stack. It owns the fetch address register. Every action
// shows up on pc_out one cycle after the edge that samples it.
module pc_stack_unit #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STACK_DEPTH  = 8,
    localparam int              CW           = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             inc,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             call_en,
    input  logic [WIDTH-1:0] call_target,
    input  logic             ret_en,
    output logic [WIDTH-1:0] pc_out,
    output logic [CW-1:0]    stack_count,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    // Stack index width; a depth that is a power of two needs one bit fewer
    // than the count.
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    // The single action chosen each cycle.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_CALL,
        ACT_CALL_REJ,
        ACT_RET,
        ACT_RET_REJ,
        ACT_BRANCH,
        ACT_INC
    } action_t;

    action_t          act;
    logic [WIDTH-1:0] pc_plus_step;
    logic [WIDTH-1:0] ret_addr;
    logic [IW-1:0]    push_idx;
    logic [IW-1:0]    top_idx;
    logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

    assign stack_full   = (stack_count == CW'(STACK_DEPTH));
    assign stack_empty  = (stack_count == '0);
    // Truncation to WIDTH bits gives the modulo wrap for free.
    assign pc_plus_step = pc_out + WIDTH'(STEP);
    // A push only happens below full, so the count fits the index width.
    assign push_idx     = IW'(stack_count);
    assign top_idx      = IW'(stack_count - CW'(1));

    // Pick one action by priority call > ret > branch > inc; stall freezes all.
    always_comb begin
        act = ACT_HOLD;
        if (!stall) begin
            if (call_en)        act = stack_full  ? ACT_CALL_REJ : ACT_CALL;
            else if (ret_en)    act = stack_empty ? ACT_RET_REJ  : ACT_RET;
            else if (branch_en) act = ACT_BRANCH;
            else if (inc)       act = ACT_INC;
        end
    end

    // Top-of-stack read, only indexed when an entry exists.
    always_comb begin
        ret_addr = '0;
        if (!stack_empty) ret_addr = stack_mem[top_idx];
    end

    // PC, stack pointer and sticky error flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            pc_out      <= RESET_VECTOR;
            stack_count <= '0;
            stack_err   <= 1'b0;
        end else begin
            unique case (act)
                ACT_CALL: begin
                    pc_out      <= call_target;
                    stack_count <= stack_count + CW'(1);
                end
                ACT_RET: begin
                    pc_out      <= ret_addr;
                    stack_count <= stack_count - CW'(1);
                end
                ACT_CALL_REJ,
                ACT_RET_REJ: stack_err <= 1'b1;
                ACT_BRANCH:  pc_out    <= branch_target;
                ACT_INC:     pc_out    <= pc_plus_step;
                default: ;
            endcase
        end
    end

    // Return-address storage, written on an accepted call.
    always_ff @(posedge clk) begin
        // NOTE: the stack array has no reset; its contents are meaningless
        // while stack_count is zero, so clearing it would only cost flops.
        if (!reset && act == ACT_CALL) stack_mem[push_idx] <= pc_plus_step;
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed bench for pc_stack_unit. Instance a: 16-bit PC, step 1, reset
// vector 0x100, two-entry stack. Instance b: 8-bit PC, step 4, reset vector 0,
// four-entry stack, for wrap and step behaviour.
module tb_pc_stack_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance a signals
    logic        a_reset, a_stall, a_inc, a_branch_en, a_call_en, a_ret_en;
    logic [15:0] a_branch_target, a_call_target, a_pc;
    logic [1:0]  a_count;
    logic        a_full, a_empty, a_err;

    // Instance b signals
    logic        b_reset, b_stall, b_inc, b_branch_en, b_call_en, b_ret_en;
    logic [7:0]  b_branch_target, b_call_target, b_pc;
    logic [2:0]  b_count;
    logic        b_full, b_empty, b_err;

    pc_stack_unit #(
        .WIDTH(16), .STEP(1), .RESET_VECTOR(16'h0100), .STACK_DEPTH(2)
    ) dut_a (
        .clk(clk), .reset(a_reset), .stall(a_stall), .inc(a_inc),
        .branch_en(a_branch_en), .branch_target(a_branch_target),
        .call_en(a_call_en), .call_target(a_call_target), .ret_en(a_ret_en),
        .pc_out(a_pc), .stack_count(a_count), .stack_full(a_full),
        .stack_empty(a_empty), .stack_err(a_err)
    );

    pc_stack_unit #(
        .WIDTH(8), .STEP(4), .RESET_VECTOR(8'h00), .STACK_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(b_reset), .stall(b_stall), .inc(b_inc),
        .branch_en(b_branch_en), .branch_target(b_branch_target),
        .call_en(b_call_en), .call_target(b_call_target), .ret_en(b_ret_en),
        .pc_out(b_pc), .stack_count(b_count), .stack_full(b_full),
        .stack_empty(b_empty), .stack_err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_reset = 0; a_stall = 0; a_inc = 0; a_branch_en = 0; a_call_en = 0; a_ret_en = 0;
    endtask

    task automatic b_idle();
        b_reset = 0; b_stall = 0; b_inc = 0; b_branch_en = 0; b_call_en = 0; b_ret_en = 0;
    endtask

    task automatic a_state(input string tag, input logic [15:0] pc, input logic [1:0] cnt,
                           input logic err);
        chk({tag, ".pc"},    32'(a_pc),    32'(pc));
        chk({tag, ".count"}, 32'(a_count), 32'(cnt));
        chk({tag, ".err"},   32'(a_err),   32'(err));
    endtask

    initial begin
        a_idle(); b_idle();
        a_branch_target = '0; a_call_target = '0;
        b_branch_target = '0; b_call_target = '0;
        b_reset = 1;

        // ---- Reset to vector: two reset cycles
        a_reset = 1;
        step(); step();
        a_reset = 0;
        a_state("rst", 16'h0100, 2'd0, 1'b0);
        chk("rst.empty", 32'(a_empty), 32'd1);
        chk("rst.full",  32'(a_full),  32'd0);

        // Three increments
        a_inc = 1;
        step(); chk("inc1.pc", 32'(a_pc), 32'h101);
        step(); chk("inc2.pc", 32'(a_pc), 32'h102);
        step(); chk("inc3.pc", 32'(a_pc), 32'h103);
        a_idle();

        // ---- Call/return nesting from 0x10
        a_branch_en = 1; a_branch_target = 16'h0010;
        step(); chk("br10.pc", 32'(a_pc), 32'h10);
        a_idle(); a_call_en = 1; a_call_target = 16'h0200;
        step(); a_state("call200", 16'h0200, 2'd1, 1'b0);
        a_idle(); a_inc = 1;
        step(); a_state("inc201", 16'h0201, 2'd1, 1'b0);
        a_idle(); a_call_en = 1; a_call_target = 16'h0300;
        step(); a_state("call300", 16'h0300, 2'd2, 1'b0);
        chk("call300.full", 32'(a_full), 32'd1);
        a_idle(); a_ret_en = 1;
        step(); a_state("ret1", 16'h0202, 2'd1, 1'b0);
        step(); a_state("ret2", 16'h0011, 2'd0, 1'b0);
        chk("ret2.empty", 32'(a_empty), 32'd1);

        // ---- Overflow: third call on a two-deep stack is rejected
        a_idle(); a_call_en = 1; a_call_target = 16'h0400;
        step(); a_state("ov.c1", 16'h0400, 2'd1, 1'b0);
        a_call_target = 16'h0600;
        step(); a_state("ov.c2", 16'h0600, 2'd2, 1'b0);
        a_call_target = 16'h0700;
        step(); a_state("ov.c3", 16'h0600, 2'd2, 1'b1);
        chk("ov.full", 32'(a_full), 32'd1);
        a_idle(); a_ret_en = 1;
        step(); a_state("ov.r1", 16'h0401, 2'd1, 1'b1);
        step(); a_state("ov.r2", 16'h0012, 2'd0, 1'b1);

        // Reset clears the sticky flag
        a_idle(); a_reset = 1;
        step(); a_state("ov.rst", 16'h0100, 2'd0, 1'b0);

        // ---- Underflow and stickiness
        a_idle(); a_branch_en = 1; a_branch_target = 16'h0040;
        step(); chk("uf.br.pc", 32'(a_pc), 32'h40);
        a_idle(); a_ret_en = 1;
        step(); a_state("uf.ret", 16'h0040, 2'd0, 1'b1);
        a_idle(); a_branch_en = 1; a_branch_target = 16'h0080;
        step(); a_state("uf.br80", 16'h0080, 2'd0, 1'b1);
        a_idle(); a_inc = 1;
        step(); a_state("uf.inc", 16'h0081, 2'd0, 1'b1);
        a_stall = 1;
        step(); a_state("uf.stall", 16'h0081, 2'd0, 1'b1);
        a_idle();
        step(); a_state("uf.hold", 16'h0081, 2'd0, 1'b1);
        a_reset = 1;
        step(); a_state("uf.rst", 16'h0100, 2'd0, 1'b0);

        // ---- Priority: all requests at once, call wins
        a_idle();
        a_call_en = 1; a_ret_en = 1; a_branch_en = 1; a_inc = 1;
        a_call_target = 16'h0500; a_branch_target = 16'h0999;
        step(); a_state("pri.call", 16'h0500, 2'd1, 1'b0);
        // Stall with a branch request: nothing moves
        a_idle(); a_stall = 1; a_branch_en = 1;
        step(); a_state("pri.stall", 16'h0500, 2'd1, 1'b0);
        // Return beats branch and inc
        a_idle(); a_ret_en = 1; a_branch_en = 1; a_inc = 1;
        step(); a_state("pri.ret", 16'h0101, 2'd0, 1'b0);
        // Rejected return still drops the branch and inc
        step(); a_state("pri.retrej", 16'h0101, 2'd0, 1'b1);
        // Branch beats inc
        a_idle(); a_branch_en = 1; a_inc = 1; a_branch_target = 16'h0777;
        step(); a_state("pri.br", 16'h0777, 2'd0, 1'b1);
        a_idle();

        // ---- Wrap and step on the 8-bit, step-4 instance
        step();
        chk("b.rst.pc", 32'(b_pc), 32'h00);
        b_idle(); b_inc = 1;
        step(); chk("b.inc.pc", 32'(b_pc), 32'h04);
        b_idle(); b_branch_en = 1; b_branch_target = 8'hFC;
        step(); chk("b.brfc.pc", 32'(b_pc), 32'hFC);
        b_idle(); b_inc = 1;
        step(); chk("b.wrap.pc", 32'(b_pc), 32'h00);
        chk("b.wrap.err", 32'(b_err), 32'd0);
        b_idle(); b_branch_en = 1; b_branch_target = 8'hFC;
        step();
        b_idle(); b_call_en = 1; b_call_target = 8'h20;
        step(); chk("b.call.pc", 32'(b_pc), 32'h20);
        chk("b.call.count", 32'(b_count), 32'd1);
        b_idle(); b_ret_en = 1;
        step(); chk("b.ret.pc", 32'(b_pc), 32'h00);
        chk("b.ret.count", 32'(b_count), 32'd0);
        b_idle(); b_call_en = 1; b_call_target = 8'h30;
        step(); chk("b.call2.count", 32'(b_count), 32'd1);
        // Reset coincident with a call: reset wins
        b_reset = 1; b_call_target = 8'h50;
        step();
        chk("b.rstcall.pc",    32'(b_pc),    32'h00);
        chk("b.rstcall.count", 32'(b_count), 32'd0);
        chk("b.rstcall.empty", 32'(b_empty), 32'd1);
        b_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program counter for the sequencer core, successor to the single-width PC. It adds a configurable increment step and reset vector, a stall input, and a hardware call/return stack of configurable depth. It sits between the instruction-fetch address path and the decode/branch logic and owns the fetch address register.

Parameters:
WIDTH, 32, PC and target width in bits (>= 4)
STEP, 1, increment added on inc; 1 for word-addressed memory, 4 for byte-addressed memory
RESET_VECTOR, 0, PC value loaded on reset (WIDTH bits)
STACK_DEPTH, 8, number of return-address entries (>= 2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset; sampled on posedge clk
stall  input  1  freezes PC, stack and flags for the cycle
inc  input  1  advance PC by STEP
branch_en  input  1  load branch_target into PC
branch_target  input  WIDTH  branch destination
call_en  input  1  push return address and load call_target
call_target  input  WIDTH  call destination
ret_en  input  1  pop return address into PC
pc_out  output  WIDTH  current PC (registered)
stack_count  output  $clog2(STACK_DEPTH+1)  occupied stack entries (registered)
stack_full  output  1  stack_count == STACK_DEPTH (combinational from the count)
stack_empty  output  1  stack_count == 0 (combinational from the count)
stack_err  output  1  sticky overflow/underflow flag (registered)

Behaviour:
- All state updates on posedge clk. Reset is synchronous and active-high; it overrides every other input.
- On reset: pc_out = RESET_VECTOR, stack_count = 0, stack_err = 0. Stack contents are don't-care.
- When stall = 1 and reset = 0, all registers hold regardless of the other inputs.
- When not stalled, exactly one action is taken per cycle, in this priority order: call_en > ret_en > branch_en > inc > hold.
- Call with the stack not full:
  - stack[stack_count] <= pc_out + STEP, truncated to WIDTH.
  - stack_count increments.
  - pc_out <= call_target.
- Call with the stack full: rejected. PC and stack are unchanged and stack_err <= 1.
- Return with the stack not empty:
  - pc_out <= stack[stack_count-1].
  - stack_count decrements.
- Return with the stack empty: rejected. PC is unchanged and stack_err <= 1.
- Branch: pc_out <= branch_target. The stack is untouched.
- Increment: pc_out <= pc_out + STEP, modulo 2^WIDTH. From all-ones with STEP = 1, the PC wraps to 0 silently and no flag is raised.
- Hold (no request): all registers keep their values.
- Lower-priority requests asserted in the same cycle as a higher-priority one are dropped, not queued. Example: call_en and ret_en together perform the call only.
- stack_err stays set until reset; a stall does not clear it.
- Latency: every action is visible on pc_out one cycle after the sampling edge. There is no combinational path from any input to pc_out.
- The stack is LIFO, implemented with a register array and a count pointer. Implementation must not read out of range: index is stack_count-1 only when stack_count > 0.

Test Plan:
- Reset to vector: RESET_VECTOR = 0x100, hold reset for 2 cycles, then release -> pc_out = 0x100, stack_count = 0, stack_empty = 1, stack_err = 0. Then inc for 3 cycles -> pc_out = 0x103.
- Call/return nesting: from pc = 0x10, call 0x200, inc, call 0x300, then ret twice -> pc sequence 0x200, 0x201, 0x300, 0x202, 0x11; stack_count sequence 1, 1, 2, 1, 0.
- Overflow: STACK_DEPTH = 2, perform 3 calls -> the third call is rejected: pc stays at the second call target, stack_count = 2, stack_full = 1, stack_err = 1. Two rets then unwind correctly.
- Underflow and stickiness: ret on an empty stack at pc = 0x40 -> pc stays 0x40 and stack_err = 1. stack_err stays 1 through subsequent branches and incs, and clears only on reset.
- Priority and stall: call_en = ret_en = branch_en = inc = 1 with call_target = 0x500 -> call taken, branch dropped. Next cycle, stall = 1 with branch_en = 1 -> pc_out stays 0x500 and stack_count is unchanged.
- Wrap and step: WIDTH = 8, STEP = 4, pc = 0xFC, inc -> pc = 0x00. Call at pc = 0xFC -> pushed return address is 0x00. Reset asserted mid-sequence, coincident with call_en -> reset wins and the stack is empty.
